// File: rtl/ddr_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr_cmd_scheduler_if
// Brief    : Request channel, DDR command pins and status flags for the
//            DDR command scheduler.
// Revision : 1.0
// ============================================================================
interface ddr_cmd_scheduler_if #(
  parameter int BA_BITS   = 2,
  parameter int ADDR_BITS = 13,
  parameter int COL_BITS  = 10
);
  logic                 Req_valid;
  logic                 Req_we;
  logic [BA_BITS-1:0]   Req_bank;
  logic [ADDR_BITS-1:0] Req_row;
  logic [COL_BITS-1:0]  Req_col;
  logic                 Req_ready;

  logic                 Cke;
  logic                 Cs_n;
  logic                 Ras_n;
  logic                 Cas_n;
  logic                 We_n;
  logic [BA_BITS-1:0]   Ba;
  logic [ADDR_BITS-1:0] Addr;

  logic                 Init_done;
  logic                 Rd_issue;
  logic                 Wr_issue;
  logic                 Ref_issue;

  modport master (
    output Req_valid, Req_we, Req_bank, Req_row, Req_col,
    input  Req_ready, Cke, Cs_n, Ras_n, Cas_n, We_n, Ba, Addr,
    input  Init_done, Rd_issue, Wr_issue, Ref_issue
  );

  modport slave (
    input  Req_valid, Req_we, Req_bank, Req_row, Req_col,
    output Req_ready, Cke, Cs_n, Ras_n, Cas_n, We_n, Ba, Addr,
    output Init_done, Rd_issue, Wr_issue, Ref_issue
  );
endinterface
`default_nettype wire

// File: rtl/ddr_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ddr_cmd_scheduler
// Brief    : Single-access DDR command scheduler: power-up init, ACTIVE then
//            READ/WRITE with auto-precharge, optional periodic refresh
//            (enabled by defining DDR_AUTO_REFRESH_EN).
// Revision : 1.0
// ============================================================================
module ddr_cmd_scheduler #(
  parameter int BA_BITS      = 2,
  parameter int ADDR_BITS    = 13,
  parameter int COL_BITS     = 10,
  parameter int INIT_WAIT    = 200,
  parameter int T_RCD        = 3,
  parameter int T_RW_DONE    = 6,
  parameter int T_RFC        = 10,
  parameter int REF_INTERVAL = 780,
  parameter logic [ADDR_BITS-1:0] MODE_REG = 13'h0022
) (
  input  logic                  Clk,
  input  logic                  Rst,
  ddr_cmd_scheduler_if.slave    bus
);

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_LMR   = 4'b0000;

  localparam logic [ADDR_BITS-1:0] A10 = ADDR_BITS'(1024);
  localparam int WAIT_A   = (INIT_WAIT > T_RFC) ? INIT_WAIT : T_RFC;
  localparam int WAIT_B   = (T_RCD > T_RW_DONE) ? T_RCD : T_RW_DONE;
  localparam int WAIT_MAX = (WAIT_A > WAIT_B) ? WAIT_A : WAIT_B;
  localparam int TW       = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ACT, S_ACT_WAIT, S_RW, S_RW_WAIT, S_REF, S_REF_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           step_q, step_d;
  logic                 cke_q, cke_d;
  logic [3:0]           cmd_q, cmd_d;
  logic [BA_BITS-1:0]   ba_q, ba_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 init_done_q, init_done_d;
  logic                 ready_q, ready_d;
  logic                 rd_q, rd_d, wr_q, wr_d, ref_q, ref_d;
  logic                 we_q, we_d;
  logic [BA_BITS-1:0]   bank_q, bank_d;
  logic [COL_BITS-1:0]  col_q, col_d;
  logic                 pend_q, pend_d;
  logic                 ref_set;

`ifdef DDR_AUTO_REFRESH_EN
  localparam int RCW = $clog2(REF_INTERVAL + 1);
  logic [RCW-1:0] ref_cnt_q, ref_cnt_d;

  // Free-running once init completes; wraps to 0 on the cycle it flags a refresh.
  always_comb begin
    ref_cnt_d = ref_cnt_q;
    ref_set   = 1'b0;
    if (init_done_q) begin
      if (ref_cnt_q == RCW'(REF_INTERVAL - 1)) begin
        ref_cnt_d = '0;
        ref_set   = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + RCW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) ref_cnt_q <= '0;
    else     ref_cnt_q <= ref_cnt_d;
  end
`else
  assign ref_set = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + TW'(1);
    step_d      = step_q;
    cke_d       = cke_q;
    cmd_d       = CMD_NOP;
    ba_d        = '0;
    addr_d      = '0;
    init_done_d = init_done_q;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    ref_d       = 1'b0;
    we_d        = we_q;
    bank_d      = bank_q;
    col_d       = col_q;
    pend_d      = pend_q | ref_set;

    case (state_q)
      S_INIT: begin
        if (step_q == 4'd0) begin
          if (timer_q == TW'(INIT_WAIT - 1)) begin
            cke_d   = 1'b1;
            step_d  = 4'd1;
            timer_d = '0;
          end
        end else if (timer_q == TW'(T_RFC - 1)) begin
          // Steps 1..7 each close with one init command; step 8 closes init.
          timer_d = '0;
          step_d  = step_q + 4'd1;
          case (step_q)
            4'd1, 4'd4: begin cmd_d = CMD_PRE; addr_d = A10; end
            4'd2:       begin cmd_d = CMD_LMR; ba_d = BA_BITS'(1); end
            4'd3:       begin cmd_d = CMD_LMR; addr_d = MODE_REG | ADDR_BITS'(13'h0100); end
            4'd5, 4'd6: begin cmd_d = CMD_REF; ref_d = 1'b1; end
            4'd7:       begin cmd_d = CMD_LMR; addr_d = MODE_REG; end
            default:    begin init_done_d = 1'b1; state_d = S_IDLE; end
          endcase
        end
      end
      S_IDLE: begin
        timer_d = '0;
        if (pend_q) begin
          state_d = S_REF;
          cmd_d   = CMD_REF;
          ref_d   = 1'b1;
          pend_d  = ref_set;
        end else if (bus.Req_valid && ready_q) begin
          state_d = S_ACT;
          cmd_d   = CMD_ACT;
          ba_d    = bus.Req_bank;
          addr_d  = bus.Req_row;
          we_d    = bus.Req_we;
          bank_d  = bus.Req_bank;
          col_d   = bus.Req_col;
        end
      end
      S_ACT, S_ACT_WAIT: begin
        if (timer_q == TW'(T_RCD - 1)) begin
          state_d = S_RW;
          timer_d = '0;
          cmd_d   = we_q ? CMD_WRITE : CMD_READ;
          ba_d    = bank_q;
          addr_d  = ADDR_BITS'(col_q) | A10;
          rd_d    = !we_q;
          wr_d    = we_q;
        end else begin
          state_d = S_ACT_WAIT;
        end
      end
      S_RW, S_RW_WAIT: begin
        if (timer_q == TW'(T_RW_DONE - 1)) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          state_d = S_RW_WAIT;
        end
      end
      S_REF, S_REF_WAIT: begin
        if (timer_q == TW'(T_RFC - 1)) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          state_d = S_REF_WAIT;
        end
      end
      default: state_d = S_INIT;
    endcase

    ready_d = (state_d == S_IDLE) && !pend_d;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_INIT;
      timer_q     <= '0;
      step_q      <= '0;
      cke_q       <= 1'b0;
      cmd_q       <= CMD_NOP;
      ba_q        <= '0;
      addr_q      <= '0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      ref_q       <= 1'b0;
      we_q        <= 1'b0;
      bank_q      <= '0;
      col_q       <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      step_q      <= step_d;
      cke_q       <= cke_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      addr_q      <= addr_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      ref_q       <= ref_d;
      we_q        <= we_d;
      bank_q      <= bank_d;
      col_q       <= col_d;
      pend_q      <= pend_d;
    end
  end

  assign bus.Cke       = cke_q;
  assign bus.Cs_n      = cmd_q[3];
  assign bus.Ras_n     = cmd_q[2];
  assign bus.Cas_n     = cmd_q[1];
  assign bus.We_n      = cmd_q[0];
  assign bus.Ba        = ba_q;
  assign bus.Addr      = addr_q;
  assign bus.Init_done = init_done_q;
  assign bus.Req_ready = ready_q;
  assign bus.Rd_issue  = rd_q;
  assign bus.Wr_issue  = wr_q;
  assign bus.Ref_issue = ref_q;

endmodule
`default_nettype wire
